bcd_convert_seq: RTL and testbench
==================================

Name: bcd_convert_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) sitting directly upstream of the eight-digit display controller. Takes a processor result word (register/ALU/memory value) and produces packed decimal digit nibbles. These nibbles drive the display controller's seg inputs, so values show in decimal rather than hex. Uses a start/busy/done handshake. The output register updates atomically, so the display never shows partial results.

Parameters:
WIDTH, 16, binary input width in bits (>= 4)
DIGITS, 5, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH

Ports:
clk  input  1  system clock (100 MHz board clock)
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to convert bin; honoured only in IDLE
bin  input  WIDTH  binary value, sampled on the clk edge where start is accepted
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse when bcd/neg have just been updated
bcd  output  4*DIGITS  packed result, digit 0 (ones) in bits [3:0], digit i in [4i+3:4i]
neg  output  1  sign of displayed value (see Optional Feature); 0 when feature absent

Behaviour:
- Reset is asynchronous and active-low: while reset=0, the following are forced.
  - Outputs: busy=0, done=0, bcd=0, neg=0.
  - Internal state: state=IDLE, shift counter=0, working shift register=0.
- State IDLE:
  - On a clk edge with start=1: latch bin into the working binary register, clear the working BCD register, counter=0, go to SHIFT.
  - start=0: stay in IDLE.
- State SHIFT, once per clock:
  - For each working BCD digit >= 5, add 3 to that digit (4-bit, per digit).
  - Then shift the combined {bcd_work, bin_work} left by 1; the MSB of bin_work enters digit 0's LSB.
  - counter increments.
  - After the WIDTH-th shift (counter == WIDTH-1 on that edge), go to DONE.
  - Add-3 is applied before each shift, never after the last.
- State DONE:
  - bcd <= bcd_work and neg <= neg_work on entry edge.
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE.
- Latency: start accepted at edge k -> done=1 and new bcd valid after edge k+WIDTH+1 (17 cycles for WIDTH=16). Next start is accepted no earlier than edge k+WIDTH+2.
- busy is registered: high from the edge after start is accepted through the DONE cycle inclusive; low in IDLE.
- start while busy=1 (SHIFT or DONE): ignored, not queued; current conversion unaffected. bin changes during busy: ignored.
- bcd/neg hold the previous result throughout a conversion. They change only on the DONE entry edge.
- Reset asserted mid-conversion: conversion abandoned, all outputs zero immediately (async). After release, IDLE, no done pulse.
- Unused high BCD digits (value smaller than the digit capacity) read 0. No leading-zero blanking here; that is the display path's concern.
- Input 0 yields all-zero bcd. Max input 2^WIDTH-1 always fits by the DIGITS constraint, so there is no overflow flag.

Optional Feature:
Macro SIGNED_DISPLAY_EN.
- Defined:
  - bin is two's complement. At the accepting edge, if bin[WIDTH-1]=1, the working binary register is loaded with the WIDTH-bit negation (unsigned magnitude) and neg_work=1; else the value is loaded unchanged and neg_work=0.
  - The most negative value (0x8000) converts to magnitude 32768.
  - neg is updated together with bcd in DONE.
  - Latency unchanged.
- Undefined: bin is unsigned, no negation logic, neg tied to 0.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, start=0 for 40 cycles -> busy=0, done=0, bcd=0x00000, neg=0 throughout.
- Pulse start with bin=16'd12345 at edge k -> busy=1 edges k+1..k+17; done=1 only in cycle after edge k+17; bcd=0x12345; bcd held at 0 before edge k+17.
- Back-to-back values: bin=16'hFFFF -> bcd=0x65535. Then start at first legal edge with bin=16'd0 -> bcd=0x00000. Then bin=16'd9 -> bcd=0x00009. Each done exactly one cycle.
- Start ignored while busy: start with bin=16'd100, pulse start with bin=16'd777 at edge k+5 and k+17 -> single done, bcd=0x00100, no second conversion.
- Reset mid-op: start with bin=16'd4321, then reset=0 at k+8 -> outputs 0 immediately. Release, no done pulse. A new start with bin=16'd42 gives bcd=0x00042.
- With SIGNED_DISPLAY_EN:
  - bin=16'hFFFF -> bcd=0x00001, neg=1.
  - bin=16'h8000 -> bcd=0x32768, neg=1.
  - bin=16'h7FFF -> bcd=0x32767, neg=0.
  - Without the macro, bin=16'hFFFF -> bcd=0x65535, neg=0.

Source files
------------

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq
// Sequential binary-to-BCD converter using shift-and-add-3 with one bit per clock.
// It feeds packed decimal digits to the eight-digit display controller.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   start       convert request, accepted only while idle
//   bin         binary value, sampled on the accepting edge
//   busy        registered, high from the edge after acceptance through the done cycle
//   done        one-cycle pulse when bcd/neg have just been updated
//   bcd         packed result, digit i in [4i+3:4i] (digit 0 = ones)
//   neg         sign of the displayed value (0 unless SIGNED_DISPLAY_EN)
//   state_dbg_o current FSM state (IDLE=0, SHIFT=1, DONE=2) for observation
//
// Handshake: a conversion starts on a clk edge where start=1 and the FSM is IDLE.
// A start that arrives at any other time is dropped, not queued.
// bcd/neg change only on the edge that raises done, so a consumer that latches on done
// never sees a partial result.
//
// Optional build macro: SIGNED_DISPLAY_EN. When it is defined, bin is two's complement.
// The converter shows the magnitude on bcd and the sign on neg.
module bcd_convert_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [1:0]            state_dbg_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     bin_work_q, bin_work_d;
  logic [4*DIGITS-1:0]  bcd_work_q, bcd_work_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [4*DIGITS-1:0]  bcd_adj;
  logic [WIDTH-1:0]     bin_load;

`ifdef SIGNED_DISPLAY_EN
  logic neg_work_q, neg_work_d;
  logic neg_q, neg_d;
  logic neg_load;

  // The negation wraps, so the most negative input loads as its own bit pattern.
  // That pattern is the correct unsigned magnitude (0x8000 -> 32768).
  always_comb begin
    neg_load = bin[WIDTH-1];
    bin_load = bin[WIDTH-1] ? WIDTH'(~bin + 1'b1) : bin;
  end
`else
  always_comb begin
    bin_load = bin;
  end
`endif

  // Add-3 correction: any digit of 5 or more would exceed 9 after the doubling shift.
  always_comb begin
    bcd_adj = bcd_work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_work_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_work_d = bin_work_q;
    bcd_work_d = bcd_work_q;
    bcd_d      = bcd_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef SIGNED_DISPLAY_EN
    neg_work_d = neg_work_q;
    neg_d      = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_work_d = bin_load;
          bcd_work_d = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
`ifdef SIGNED_DISPLAY_EN
          neg_work_d = neg_load;
`endif
        end
      end
      SHIFT: begin
        busy_d     = 1'b1;
        bcd_work_d = {bcd_adj[4*DIGITS-2:0], bin_work_q[WIDTH-1]};
        bin_work_d = {bin_work_q[WIDTH-2:0], 1'b0};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The result is published here, so the done pulse and busy both appear in the
        // cycle after this edge. The FSM is already back in IDLE by then.
        bcd_d   = bcd_work_q;
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SIGNED_DISPLAY_EN
        neg_d   = neg_work_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_work_q <= '0;
      bcd_work_q <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
      neg_work_q <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_work_q <= bin_work_d;
      bcd_work_q <= bcd_work_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SIGNED_DISPLAY_EN
      neg_work_q <= neg_work_d;
      neg_q      <= neg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign bcd         = bcd_q;
  assign state_dbg_o = state_q;
`ifdef SIGNED_DISPLAY_EN
  assign neg         = neg_q;
`else
  assign neg         = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
module tb_bcd_convert_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = WIDTH + 1;

  logic                clk;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                neg;
  logic [1:0]          state_dbg;

  // Scoreboard entries are {neg, bcd}.
  logic [4*DIGITS:0] exp_q[$];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  bcd_convert_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bin         (bin),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .neg         (neg),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [4*DIGITS:0] model(input logic [WIDTH-1:0] v);
    int unsigned         m;
    logic                n;
    logic [4*DIGITS-1:0] r;
    m = v;
    n = 1'b0;
`ifdef SIGNED_DISPLAY_EN
    if (v[WIDTH-1]) begin
      m = (1 << WIDTH) - int'(v);
      n = 1'b1;
    end
`endif
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {n, r};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Runs one conversion of v. inj_a and inj_b are cycle offsets after the accepting
  // edge at which a competing start (bin=777) is pulsed. Use 0 for no injection.
  task automatic convert(input logic [WIDTH-1:0] v, input int inj_a, input int inj_b);
    logic [4*DIGITS:0] prev, exp;
    int lat, busy_bad, hold_bad;
    lat = 0; busy_bad = 0; hold_bad = 0;
    @(negedge clk);
    prev  = {neg, bcd};
    bin   = v;
    start = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk);
    #1 start = 1'b0;
    bin = $urandom_range(0, 65535);
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (c == inj_a || c == inj_b) begin
        @(negedge clk);
        bin   = 16'd777;
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) lat = c;
      else if ({neg, bcd} !== prev) hold_bad++;
    end
    check("latency", lat, LAT);
    check("busy_during_conv", busy_bad, 0);
    check("result_held", hold_bad, 0);
    exp = exp_q.pop_front();
    check("bcd", bcd, exp[4*DIGITS-1:0]);
    check("neg", neg, exp[4*DIGITS]);
  endtask

  // Idle for n cycles with start low. Expects no done pulse and busy low from the
  // second sample onward.
  task automatic idle_check(input string tag, input int n);
    int dones, busys;
    dones = 0; busys = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) dones++;
      if (c > 0 && busy !== 1'b0) busys++;
    end
    check({tag, "_no_done"}, dones, 0);
    check({tag, "_idle_busy"}, busys, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    reset = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_neg", neg, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b1;

    // Reset, then stay idle for 40 cycles.
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0 || neg !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Basic conversion.
    convert(16'd12345, 0, 0);
    idle_check("after_12345", 3);

    // Back-to-back conversions, each started at the first legal edge.
    convert(16'hFFFF, 0, 0);
    convert(16'd0, 0, 0);
    convert(16'd9, 0, 0);
    idle_check("after_b2b", 3);

    // Start pulses during busy must be ignored, including one at the DONE edge.
    convert(16'd100, 5, LAT);
    idle_check("after_ignored", 25);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin   = 16'd4321;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_bcd", bcd, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_neg", neg, 0);
    @(negedge clk);
    reset = 1'b1;
    idle_check("after_midrst", 30);
    check("midrst_bcd_still0", bcd, 0);
    convert(16'd42, 0, 0);

    // Values that differ between the signed and unsigned builds.
    convert(16'h8000, 0, 0);
    convert(16'h7FFF, 0, 0);
    convert(16'hFFFF, 0, 0);

    // Random values.
    for (int i = 0; i < 4; i++) begin
      convert(16'($urandom_range(0, 65535)), 0, 0);
    end
    idle_check("final", 3);

    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
